// File: rtl/imul_arb_pkg.sv
// Shared types and constants for the integer-multiplier arbiter.
package imul_arb_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } state_t;

  localparam int unsigned IMUL_REQ_NBITS  = 64;
  localparam int unsigned IMUL_RESP_NBITS = 32;

endpackage

// File: rtl/imul_rr_picker.sv
// Combinational round-robin search: first asserted request at or after ptr, with wrap.
module imul_rr_picker
  import imul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  g
);

  logic [IDW-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    any   = 1'b0;
    g     = '0;
    w_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      // Explicit modulo keeps the wrap correct when NREQ is not a power of two.
      w_idx = IDW'((int'(ptr) + k) % int'(NREQ));
      if (req[w_idx]) begin
        any = 1'b1;
        g   = w_idx;
      end
    end
  end

endmodule

// File: rtl/imul_int_mul_arbiter.sv
// Round-robin arbiter sharing one variable-latency multiplier among NREQ requesters.
// The winner owns the multiplier from request handshake until its product is consumed.
module imul_int_mul_arbiter
  import imul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req_val,
  output logic [NREQ-1:0]                  req_rdy,
  input  logic [NREQ*IMUL_REQ_NBITS-1:0]   req_msg,
  output logic [NREQ-1:0]                  resp_val,
  input  logic [NREQ-1:0]                  resp_rdy,
  output logic [IMUL_RESP_NBITS-1:0]       resp_msg,
  output logic                             mul_recv_val,
  input  logic                             mul_recv_rdy,
  output logic [IMUL_REQ_NBITS-1:0]        mul_recv_msg,
  input  logic                             mul_send_val,
  output logic                             mul_send_rdy,
  input  logic [IMUL_RESP_NBITS-1:0]       mul_send_msg,
  output logic                             busy,
  output logic [IDW-1:0]                   owner
);

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_next;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner_next;
  logic           w_any;
  logic [IDW-1:0] w_g;

  imul_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req (req_val),
    .ptr (r_ptr),
    .any (w_any),
    .g   (w_g)
  );

  // State, round-robin pointer and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
    end
  end

  // Next-state logic, request mux and response demux.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    req_rdy      = '0;
    resp_val     = '0;
    resp_msg     = '0;
    mul_recv_val = 1'b0;
    mul_recv_msg = '0;
    mul_send_rdy = 1'b0;
    // Handshake outputs stay quiet during reset so nothing fires in the reset cycle.
    if (!reset) begin
      case (r_state)
        STATE_IDLE: begin
          // mul_send_val here is a protocol error; no ready is given for it.
          if (w_any) begin
            mul_recv_val = 1'b1;
            mul_recv_msg = req_msg[w_g*IMUL_REQ_NBITS +: IMUL_REQ_NBITS];
            req_rdy[w_g] = mul_recv_rdy;
            if (mul_recv_rdy) begin
              w_owner_next = w_g;
              w_state_next = STATE_WAIT;
            end
          end
        end
        STATE_WAIT: begin
          resp_val[r_owner] = mul_send_val;
          mul_send_rdy      = resp_rdy[r_owner];
          resp_msg          = mul_send_msg;
          if (mul_send_val && resp_rdy[r_owner]) begin
            w_state_next = STATE_IDLE;
            // The requester just served drops to lowest priority.
            w_ptr_next   = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == STATE_WAIT);
  assign owner = r_owner;

endmodule

// File: doc/imul_int_mul_arbiter.md
# imul_int_mul_arbiter

Shares a single variable-latency integer multiplier (64-bit request `{a,b}`, 32-bit product, val/rdy on both sides) among `NREQ` requesters. Each requester sees its own val/rdy request and response port. Requests are granted in round-robin order. The block then holds ownership of the multiplier until that requester has consumed the product, and routes the product back to it. It sits between the processor-side clients (multiple cores or test sources) and the multiplier instance.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `IDW`, default `$clog2(NREQ)`: width of the grant id.

- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `req_val`, input, `NREQ`: per-requester request valid.
- `req_rdy`, output, `NREQ`: per-requester request ready.
- `req_msg`, input, `NREQ*64`: requester i occupies bits `[64*i+63:64*i]`, laid out `{a[31:0], b[31:0]}`.
- `resp_val`, output, `NREQ`: per-requester response valid.
- `resp_rdy`, input, `NREQ`: per-requester response ready.
- `resp_msg`, output, 32: product, broadcast to all requesters and qualified by `resp_val`.
- `mul_recv_val`, output, 1: request valid to the multiplier.
- `mul_recv_rdy`, input, 1: multiplier request ready.
- `mul_recv_msg`, output, 64: selected request.
- `mul_send_val`, input, 1: multiplier product valid.
- `mul_send_rdy`, output, 1: product ready to the multiplier.
- `mul_send_msg`, input, 32: product.
- `busy`, output, 1: high when the block is in WAIT.
- `owner`, output, `IDW`: latched grant id; meaningful only while `busy`.

## Operation
- The state machine has two states, IDLE and WAIT. The block also keeps a round-robin pointer `ptr` (`IDW` bits) and a grant register `owner`.
- **IDLE**
  - Each cycle, combinationally pick the first `i` with `req_val[i]`, searching from `ptr` upward with wrap-around; call it `g`.
  - If any `req_val` is high: `mul_recv_val=1`, `mul_recv_msg=req_msg[g]`, `req_rdy[g]=mul_recv_rdy`. All other `req_rdy` bits are 0.
  - If no `req_val` is high: `mul_recv_val=0` and all `req_rdy` are 0.
  - On the handshake (`mul_recv_val && mul_recv_rdy`): `owner<=g`, go to WAIT.
  - The grant is not sticky before the handshake. `g` is recomputed every cycle, so a requester may drop `req_val` without penalty.
- **WAIT**
  - All `req_rdy` are 0 and `mul_recv_val=0`.
  - `resp_val[owner]=mul_send_val` and every other `resp_val` bit is 0.
  - `mul_send_rdy=resp_rdy[owner]` and `resp_msg=mul_send_msg`.
  - On the handshake (`mul_send_val && mul_send_rdy`): `ptr<=owner+1` (modulo `NREQ`), go to IDLE.
- Outside WAIT, all `resp_val` bits and `mul_send_rdy` are 0. `resp_msg` is 0 outside WAIT.
- `mul_send_val` asserted while in IDLE is a protocol error. It is ignored (the block asserts no ready); the testbench flags it.
- The requester order after a completed transaction is fixed: the requester just served gets the lowest priority next time.

## Timing
- Reset values: state=IDLE, `ptr=0`, `owner=0`, `busy=0`.
  - All `req_rdy`, `resp_val`, `mul_recv_val` and `mul_send_rdy` are 0 in the reset cycle.
  - `resp_msg=0`.
- The block adds zero cycles of latency. Requests and responses pass through combinationally.
- Back-to-back operation: the product handshake in WAIT is followed by IDLE on the next cycle. A new request can be accepted in that IDLE cycle, as soon as the multiplier reports `recv_rdy`.
- A requester that stalls `resp_rdy` holds the multiplier. Other requesters wait; there is no timeout.
- Reset asserted mid-transaction (in WAIT) returns the block to IDLE with `ptr=0`. The multiplier shares the same reset, so the in-flight product is discarded.
- `NREQ` not a power of two: wrap `ptr` explicitly (`ptr==NREQ-1` leads to 0).

## Structure
- Shared package `imul_arb_pkg`:
  - state constants `STATE_IDLE=1'b0` and `STATE_WAIT=1'b1`;
  - `IMUL_REQ_NBITS=64` and `IMUL_RESP_NBITS=32`.
- Sub-module `imul_rr_picker`: combinational priority search.
  - Inputs: `req[NREQ]` and `ptr`.
  - Outputs: `any` and grant index `g`.
- The top level holds the state machine, the `ptr` and `owner` registers, the request mux and the response demux.

## Test plan
1. **Single request:** after reset, req0 sends `{a=3,b=5}`. Required: `mul_recv_msg=0x0000000300000005`, then `resp_val[0]=1` with `resp_msg=15`, and `ptr=1` after the response handshake.
2. **Simultaneous requests:** all four requesters assert `req_val` at once with `b=i+2` and `a=7`. Required: service order 0,1,2,3, with products 14, 21, 28, 35 each appearing only on the owning `resp_val`.
3. **Round-robin fairness:** req1 and req3 request continuously while `ptr` starts at 2. Required: grants alternate 3,1,3,1.
4. **Response backpressure:** owner holds `resp_rdy=0` for 10 cycles while req2 is pending. Required: `mul_send_rdy=0`, state stays WAIT, `req_rdy[2]=0` throughout, and req2 is granted on the cycle after the response is accepted.
5. **Request withdrawn:** req0 asserts `req_val` while `mul_recv_rdy=0`, then drops it; req1 is also pending. Required: grant moves to req1 with no spurious transaction.
6. **Reset mid-transaction:** reset asserted in WAIT. Required: next cycle is IDLE with `busy=0`, all `resp_val=0` and `ptr=0`, and a fresh `{a=0xFFFFFFFF,b=2}` then returns `0xFFFFFFFE`.
